// File: rtl/region_gesture_filter.sv
// region_gesture_filter
//   Debounces the four per-region colour tracker detection bits into a single
//   player selection event. The detection bits are sampled once per frame (on
//   frame_end). A region must be the only one detected for CONFIRM_FRAMES
//   consecutive frames before one event is emitted. The filter then stays
//   locked until that region has been absent for RELEASE_FRAMES consecutive
//   frames, after which it re-arms.
//
// Parameters
//   CONFIRM_FRAMES : consecutive single-region frames needed for an event (1..15)
//   RELEASE_FRAMES : consecutive frames without the locked region to re-arm (1..15)
//   CNT_W          : frame counter width, must hold both frame counts
//
// Ports
//   clk          : pixel clock shared with the trackers
//   rst_n        : asynchronous active-low reset
//   enable       : block enable; low clears all state synchronously
//   frame_end    : one-cycle pulse on the last pixel of a frame
//   det[3:0]     : detection bits (0 red, 1 green, 2 yellow, 3 blue)
//   region_valid : one-cycle selection event pulse
//   region_code  : region of the last event, held between events
//   region_held  : high while locked on a region
//   multi_err    : one-cycle pulse when a sampled frame has >= 2 bits set
//   state_dbg    : current state (IDLE=0, CAND=1, LOCKED=2)
module region_gesture_filter #(
  parameter int unsigned CONFIRM_FRAMES = 3,
  parameter int unsigned RELEASE_FRAMES = 2,
  parameter int unsigned CNT_W          = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       frame_end,
  input  logic [3:0] det,
  output logic       region_valid,
  output logic [1:0] region_code,
  output logic       region_held,
  output logic       multi_err,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CAND   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CONF_TGT = CNT_W'(CONFIRM_FRAMES);
  localparam logic [CNT_W-1:0] REL_TGT  = CNT_W'(RELEASE_FRAMES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state, state_n;
  logic [1:0]       cand, cand_n;
  logic [CNT_W-1:0] conf_cnt, conf_n;
  logic [CNT_W-1:0] rel_cnt, rel_n;
  logic             valid_n;
  logic [1:0]       code_n;
  logic             held_n;
  logic             multi_n;

  // Frame classification
  logic             single;
  logic             multi;
  logic [1:0]       hit_idx;
  logic [CNT_W-1:0] conf_inc;
  logic [CNT_W-1:0] rel_inc;

  always_comb begin
    single  = 1'b0;
    hit_idx = 2'd0;
    unique case (det)
      4'b0001: begin single = 1'b1; hit_idx = 2'd0; end
      4'b0010: begin single = 1'b1; hit_idx = 2'd1; end
      4'b0100: begin single = 1'b1; hit_idx = 2'd2; end
      4'b1000: begin single = 1'b1; hit_idx = 2'd3; end
      default: begin single = 1'b0; hit_idx = 2'd0; end
    endcase
    // Anything non-zero that is not one-hot has at least two bits set.
    multi = !single && (det != 4'b0000);
  end

  // Saturating increments; counters never wrap.
  always_comb begin
    conf_inc = (conf_cnt == CNT_MAX) ? conf_cnt : conf_cnt + CNT_ONE;
    rel_inc  = (rel_cnt  == CNT_MAX) ? rel_cnt  : rel_cnt  + CNT_ONE;
  end

  // Next-state and output decode
  always_comb begin
    state_n = state;
    cand_n  = cand;
    conf_n  = conf_cnt;
    rel_n   = rel_cnt;
    valid_n = 1'b0;
    code_n  = region_code;
    multi_n = 1'b0;

    if (!enable) begin
      state_n = IDLE;
      cand_n  = 2'd0;
      conf_n  = '0;
      rel_n   = '0;
      code_n  = 2'd0;
    end else if (frame_end) begin
      multi_n = multi;
      unique case (state)
        IDLE: begin
          if (single) begin
            cand_n = hit_idx;
            conf_n = CNT_ONE;
            if (CONF_TGT <= CNT_ONE) begin
              state_n = LOCKED;
              rel_n   = '0;
              valid_n = 1'b1;
              code_n  = hit_idx;
            end else begin
              state_n = CAND;
            end
          end
        end

        CAND: begin
          if (single && (hit_idx == cand)) begin
            conf_n = conf_inc;
            if (conf_inc >= CONF_TGT) begin
              state_n = LOCKED;
              rel_n   = '0;
              valid_n = 1'b1;
              code_n  = cand;
            end
          end else if (single) begin
            // A different single region restarts the candidate count.
            cand_n = hit_idx;
            conf_n = CNT_ONE;
          end else begin
            state_n = IDLE;
            conf_n  = '0;
          end
        end

        LOCKED: begin
          if (single && (hit_idx == region_code)) begin
            rel_n = '0;
          end else begin
            // Other regions only count towards release; they are not
            // recognised until the filter has returned to IDLE.
            rel_n = rel_inc;
            if (rel_inc >= REL_TGT) begin
              state_n = IDLE;
              conf_n  = '0;
              rel_n   = '0;
            end
          end
        end

        default: begin
          state_n = IDLE;
          conf_n  = '0;
          rel_n   = '0;
        end
      endcase
    end

    // region_held tracks the state register exactly by loading the next state.
    held_n = (state_n == LOCKED);
  end

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cand     <= 2'd0;
      conf_cnt <= '0;
      rel_cnt  <= '0;
    end else begin
      state    <= state_n;
      cand     <= cand_n;
      conf_cnt <= conf_n;
      rel_cnt  <= rel_n;
    end
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      region_valid <= 1'b0;
      region_code  <= 2'd0;
      region_held  <= 1'b0;
      multi_err    <= 1'b0;
    end else begin
      region_valid <= valid_n;
      region_code  <= code_n;
      region_held  <= held_n;
      multi_err    <= multi_n;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_region_gesture_filter.sv
module tb_region_gesture_filter;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       frame_end;
  logic [3:0] det;
  logic       region_valid;
  logic [1:0] region_code;
  logic       region_held;
  logic       multi_err;
  logic [1:0] state_dbg;

  region_gesture_filter #(
    .CONFIRM_FRAMES(3),
    .RELEASE_FRAMES(2),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .frame_end(frame_end),
    .det(det),
    .region_valid(region_valid),
    .region_code(region_code),
    .region_held(region_held),
    .multi_err(multi_err),
    .state_dbg(state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] det;
    logic       v;
    logic [1:0] code;
    logic       held;
    logic       m;
    logic [1:0] st;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[$];
  int   n_total = 0;
  int   n_pass  = 0;

  function automatic vec_t mk(input logic [3:0] d, input logic v, input logic [1:0] code,
                              input logic held, input logic m, input logic [1:0] st);
    vec_t r;
    r.det = d; r.v = v; r.code = code; r.held = held; r.m = m; r.st = st;
    return r;
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check_out(input string tag);
    vec_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 4'd1, 4'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_valid"}, {3'b0, region_valid}, {3'b0, e.v});
      chk({tag, "_code"},  {2'b0, region_code},  {2'b0, e.code});
      chk({tag, "_held"},  {3'b0, region_held},  {3'b0, e.held});
      chk({tag, "_multi"}, {3'b0, multi_err},    {3'b0, e.m});
      chk({tag, "_state"}, {2'b0, state_dbg},    {2'b0, e.st});
    end
  endtask

  // One frame: drive det with a frame_end pulse, expect outputs one edge later,
  // then confirm the one-cycle pulses have dropped during the gap cycles.
  task automatic do_frame(input string tag, input vec_t e, input int gap);
    @(negedge clk);
    det = e.det;
    frame_end = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    frame_end = 1'b0;
    check_out(tag);
    for (int g = 0; g < gap; g++) begin
      @(posedge clk);
      #1;
      chk({tag, "_gap_valid"}, {3'b0, region_valid}, 4'd0);
      chk({tag, "_gap_multi"}, {3'b0, multi_err},    4'd0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, {3'b0, region_valid}, 4'd0);
    chk({tag, "_code"},  {2'b0, region_code},  4'd0);
    chk({tag, "_held"},  {3'b0, region_held},  4'd0);
    chk({tag, "_multi"}, {3'b0, multi_err},    4'd0);
    chk({tag, "_state"}, {2'b0, state_dbg},    4'd0);
  endtask

  initial begin
    int bad;
    rst_n = 1'b0; enable = 1'b1; frame_end = 1'b0; det = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk); rst_n = 1'b1;

    // Expected values for CONFIRM_FRAMES=3, RELEASE_FRAMES=2.
    // Confirm on green
    tbl.push_back(mk(4'b0010, 0, 0, 0, 0, 1));
    tbl.push_back(mk(4'b0010, 0, 0, 0, 0, 1));
    tbl.push_back(mk(4'b0010, 1, 1, 1, 0, 2));
    // Release with an interrupting green frame
    tbl.push_back(mk(4'b0000, 0, 1, 1, 0, 2));
    tbl.push_back(mk(4'b0010, 0, 1, 1, 0, 2));
    tbl.push_back(mk(4'b0000, 0, 1, 1, 0, 2));
    tbl.push_back(mk(4'b0000, 0, 1, 0, 0, 0));
    tbl.push_back(mk(4'b0010, 0, 1, 0, 0, 1));
    tbl.push_back(mk(4'b0010, 0, 1, 0, 0, 1));
    tbl.push_back(mk(4'b0010, 1, 1, 1, 0, 2));
    // Multi while locked counts towards release only
    tbl.push_back(mk(4'b0110, 0, 1, 1, 1, 2));
    tbl.push_back(mk(4'b0010, 0, 1, 1, 0, 2));
    // Different single region while locked is not recognised
    tbl.push_back(mk(4'b1000, 0, 1, 1, 0, 2));
    tbl.push_back(mk(4'b1000, 0, 1, 0, 0, 0));
    // Restart
    tbl.push_back(mk(4'b0001, 0, 1, 0, 0, 1));
    tbl.push_back(mk(4'b0001, 0, 1, 0, 0, 1));
    tbl.push_back(mk(4'b1000, 0, 1, 0, 0, 1));
    tbl.push_back(mk(4'b1000, 0, 1, 0, 0, 1));
    tbl.push_back(mk(4'b1000, 1, 3, 1, 0, 2));
    tbl.push_back(mk(4'b0000, 0, 3, 1, 0, 2));
    tbl.push_back(mk(4'b0000, 0, 3, 0, 0, 0));
    // Interrupted candidate, then multi in CAND
    tbl.push_back(mk(4'b0100, 0, 3, 0, 0, 1));
    tbl.push_back(mk(4'b0000, 0, 3, 0, 0, 0));
    tbl.push_back(mk(4'b0100, 0, 3, 0, 0, 1));
    tbl.push_back(mk(4'b0100, 0, 3, 0, 0, 1));
    tbl.push_back(mk(4'b0110, 0, 3, 0, 1, 0));
    tbl.push_back(mk(4'b0000, 0, 3, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) do_frame($sformatf("tbl%0d", i), tbl[i], 2);

    // Back-to-back frame_end pulses are separate frames
    do_frame("b2b0", mk(4'b0001, 0, 3, 0, 0, 1), 0);
    do_frame("b2b1", mk(4'b0001, 0, 3, 0, 0, 1), 0);
    do_frame("b2b2", mk(4'b0001, 1, 0, 1, 0, 2), 0);
    do_frame("b2b3", mk(4'b0000, 0, 0, 1, 0, 2), 0);
    do_frame("b2b4", mk(4'b0000, 0, 0, 0, 0, 0), 1);

    // Long hold on green: one event only, rel/conf saturation harmless
    do_frame("hold_a", mk(4'b0010, 0, 0, 0, 0, 1), 1);
    do_frame("hold_b", mk(4'b0010, 0, 0, 0, 0, 1), 1);
    do_frame("hold_c", mk(4'b0010, 1, 1, 1, 0, 2), 1);
    for (int i = 0; i < 40; i++) do_frame("hold", mk(4'b0010, 0, 1, 1, 0, 2), 1);
    do_frame("hold_r0", mk(4'b0000, 0, 1, 1, 0, 2), 1);
    do_frame("hold_r1", mk(4'b0000, 0, 1, 0, 0, 0), 1);

    // No frame_end: det toggling must not move the state or counters
    do_frame("nf0", mk(4'b0100, 0, 1, 0, 0, 1), 1);
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      det = 4'($urandom_range(0, 15));
      @(posedge clk);
      #1;
      if (state_dbg !== 2'd1 || region_valid !== 1'b0 || multi_err !== 1'b0) bad++;
    end
    chk("noframe_bad_cycles", 4'(bad > 15 ? 15 : bad), 4'd0);
    do_frame("nf1", mk(4'b0100, 0, 1, 0, 0, 1), 1);
    do_frame("nf2", mk(4'b0100, 1, 2, 1, 0, 2), 1);

    // enable low while locked clears everything including region_code
    @(negedge clk); enable = 1'b0;
    @(posedge clk); #1;
    check_all_zero("en_locked");
    @(negedge clk); enable = 1'b1;

    // Asynchronous reset mid-CAND
    do_frame("rst0", mk(4'b0010, 0, 0, 0, 0, 1), 1);
    do_frame("rst1", mk(4'b0010, 0, 0, 0, 0, 1), 1);
    @(negedge clk); rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(negedge clk); rst_n = 1'b1;

    // enable low: frames ignored
    enable = 1'b0;
    for (int i = 0; i < 5; i++) do_frame("en_off", mk(4'b0010, 0, 0, 0, 0, 0), 1);
    enable = 1'b1;
    // Count was lost: a fresh three frames are needed
    do_frame("fresh0", mk(4'b0010, 0, 0, 0, 0, 1), 1);
    do_frame("fresh1", mk(4'b0010, 0, 0, 0, 0, 1), 1);
    // enable low for one cycle mid-CAND discards the count
    @(negedge clk); enable = 1'b0;
    @(posedge clk); #1;
    check_all_zero("en_cand");
    @(negedge clk); enable = 1'b1;
    do_frame("fresh2", mk(4'b0010, 0, 0, 0, 0, 1), 1);
    do_frame("fresh3", mk(4'b0010, 0, 0, 0, 0, 1), 1);
    do_frame("fresh4", mk(4'b0010, 1, 1, 1, 0, 2), 2);

    chk("sb_drained", 4'(sb.size() > 15 ? 15 : sb.size()), 4'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global time bound
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete (%0d/%0d so far)", n_pass, n_total);
    $fatal(1);
  end

endmodule

// File: doc/region_gesture_filter.md
Name: region_gesture_filter

Overview:
- Downstream of the four per-region colour trackers (red, green, yellow, blue). Each tracker drives one detection bit.
- Samples the four bits once per frame and requires the same single region on CONFIRM_FRAMES consecutive frames.
- Then emits one registered selection event with a 2-bit region code, and re-arms only after the region has been absent for RELEASE_FRAMES frames.
- Its output is the debounced player input to the game/control logic.

Parameters:
- CONFIRM_FRAMES, 3, consecutive frames with the same single region needed to emit an event (legal 1..15).
- RELEASE_FRAMES, 2, consecutive frames without the locked region needed to re-arm (legal 1..15).
- CNT_W, 4, width of the internal frame counters; must hold max(CONFIRM_FRAMES, RELEASE_FRAMES).

Ports:
- clk, input, 1, pixel clock shared with the trackers.
- rst_n, input, 1, asynchronous active-low reset.
- enable, input, 1, block enable (driven from SW[0]); low = synchronous clear.
- frame_end, input, 1, one-cycle pulse on the last pixel of the frame (x=639, y=479), before the trackers clear at x=0, y=0.
- det, input, 4, tracker detection bits; bit0 red, bit1 green, bit2 yellow, bit3 blue.
- region_valid, output, 1, one-cycle event pulse.
- region_code, output, 2, region of the last event (0 red, 1 green, 2 yellow, 3 blue); holds between events.
- region_held, output, 1, high while in LOCKED.
- multi_err, output, 1, one-cycle pulse when a sampled frame has two or more det bits set.
- state_dbg, output, 2, current state encoding (IDLE=0, CAND=1, LOCKED=2).

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, cand=0, conf_cnt=0, rel_cnt=0.
  - All outputs 0.
- enable low:
  - Clears state and counters exactly as reset, synchronously on the clk edge.
  - All outputs driven 0; frame_end ignored.
  - region_code also clears to 0.
- Frame classification:
  - Happens only on cycles with frame_end=1 and enable=1; det is sampled in that same cycle.
  - SINGLE(r): exactly one det bit set, r = its index.
  - NONE: det=0.
  - MULTI: popcount(det) >= 2. multi_err pulses on the next edge; MULTI is otherwise handled as NONE.
- Cycles without frame_end leave state and counters unchanged.
- IDLE:
  - SINGLE(r): cand=r, conf_cnt=1. Go to CAND, or go straight to LOCKED with an event if CONFIRM_FRAMES=1.
  - NONE/MULTI: stay.
- CAND:
  - SINGLE(cand): conf_cnt+1. If that reaches CONFIRM_FRAMES, go to LOCKED, rel_cnt=0, emit event.
  - SINGLE(r != cand): cand=r, conf_cnt=1, stay in CAND (restart).
  - NONE/MULTI: go to IDLE, conf_cnt=0.
- LOCKED:
  - SINGLE(region_code): rel_cnt=0.
  - Anything else, including a different single region: rel_cnt+1. If that reaches RELEASE_FRAMES, go to IDLE, conf_cnt=0, rel_cnt=0.
  - A new region is not recognised until release completes. The first frame sampled in IDLE after release starts a fresh candidate.
- Event:
  - region_valid=1 and region_code=cand, registered on the frame_end edge that confirms.
  - Visible in the cycle after that frame_end; latency 1 clk.
  - region_valid low on every other cycle.
- Counters saturate at 2^CNT_W-1 and never wrap.
- frame_end on consecutive cycles: each pulse is treated as a separate frame.
- Reset or enable low during CAND or LOCKED: the count is lost and no event is emitted.
- region_held = (state==LOCKED), registered.

Test Plan (CONFIRM_FRAMES=3, RELEASE_FRAMES=2):
- Reset/enable:
  - Assert rst_n=0 mid-CAND → all outputs 0 immediately, state_dbg=0.
  - Then enable=0 with 5 frames of det=0010 → no event.
- Confirm:
  - 3 frames of det=0010 → region_valid high exactly 1 cycle after the 3rd frame_end, region_code=1, region_held=1.
  - No pulse after frames 1–2.
- Restart:
  - Frames det=0001, 0001, 1000, 1000, 1000 → a single event with region_code=3, after the 5th frame.
  - Frames det=0100, 0000, 0100, 0100 → no event.
- Release:
  - From LOCKED on green, frames 0000, 0010, 0000, 0000, then 0010×3.
  - The 0010 resets rel_cnt. Release happens after the 4th frame.
  - A second event (region_code=1) follows after the 7th frame.
- Multi:
  - In CAND, a frame with det=0110 → multi_err pulses 1 cycle and state returns to IDLE.
  - In LOCKED, a single 0110 frame → rel_cnt=1, still LOCKED.
- Saturation/no-frame:
  - Hold LOCKED on green for 40 frames → no extra events.
  - Toggle det without frame_end for 1000 cycles → state unchanged.
